// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Round-robin arbiter sharing one single-port memory between an
//            instruction-fetch port and a data load/store port.
// Revision : 1.0 - initial release
// ============================================================================

module mem_port_arbiter #(
    parameter int AW  = 16,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(LAT - 1);

    state_t        state_q,      state_d;
    logic [2:0]    cnt_q,        cnt_d;
    logic          last_owner_q, last_owner_d;   // 1: data port won last
    logic          owner_q,      owner_d;        // 1: outstanding read is data
    logic [DW-1:0] if_rdata_q,   if_rdata_d;
    logic [DW-1:0] d_rdata_q,    d_rdata_d;

    logic          grant_if;
    logic          grant_d;

    // Grants only in IDLE; reset gates them so every output reads 0 while held.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (if_req && d_req) begin
                grant_if = last_owner_q;
                grant_d  = !last_owner_q;
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_if) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end else if (grant_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_if || grant_d) begin
                    last_owner_d = grant_d;
                    // Writes complete in the grant cycle; only reads wait.
                    if (grant_if || !d_we) begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_LOAD;
                        owner_d = grant_d;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign if_rvalid = (state_q == RESP) && !owner_q;
    assign d_rvalid  = (state_q == RESP) &&  owner_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Function : Directed self-checking bench with a timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          reset, reset3;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;

    logic          if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    logic          if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, mem_en3, mem_we3, busy3;
    logic [DW-1:0] if_rdata3, d_rdata3, mem_wdata3;
    logic [AW-1:0] mem_addr3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(3)) dut3 (
        .clk(clk), .reset(reset3),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .busy(busy3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Reference model: the memory is free from cycle free_at on; a read granted
    // at cycle T captures mem_rdata at T+L and responds at T+L+1.
    int unsigned   mcyc    = 0;
    int unsigned   free_at = 0;
    int unsigned   cap_at  = 0;
    int unsigned   resp_at = 0;
    bit            pend    = 1'b0;
    bit            pend_d  = 1'b0;
    bit            last_d  = 1'b1;
    logic [DW-1:0] pend_data  = '0;
    logic [DW-1:0] e_if_rdata = '0;
    logic [DW-1:0] e_d_rdata  = '0;

    always @(negedge clk) begin
        logic          e_ig, e_dg, e_en, e_we, e_irv, e_drv, e_busy;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit            idle;
        e_ig = 0; e_dg = 0; e_en = 0; e_we = 0; e_irv = 0; e_drv = 0; e_busy = 0;
        e_addr = '0;
        e_wd   = '0;
        if (reset) begin
            free_at    = mcyc + 1;
            pend       = 1'b0;
            last_d     = 1'b1;
            e_if_rdata = '0;
            e_d_rdata  = '0;
        end else begin
            if (pend && mcyc == cap_at) pend_data = mem_rdata;
            if (pend && mcyc == resp_at) begin
                if (pend_d) begin
                    e_d_rdata = pend_data;
                    e_drv     = 1'b1;
                end else begin
                    e_if_rdata = pend_data;
                    e_irv      = 1'b1;
                end
                pend = 1'b0;
            end
            idle   = (mcyc >= free_at);
            e_busy = !idle;
            if (idle) begin
                if (if_req && d_req) begin
                    e_ig = last_d;
                    e_dg = !last_d;
                end else begin
                    e_ig = if_req;
                    e_dg = d_req;
                end
            end
            if (e_ig) begin
                e_en = 1; e_addr = if_addr;
            end else if (e_dg) begin
                e_en = 1; e_we = d_we; e_addr = d_addr; e_wd = d_wdata;
            end
            if (e_ig || e_dg) begin
                last_d = e_dg;
                if (e_dg && d_we) begin
                    free_at = mcyc + 1;
                end else begin
                    free_at = mcyc + L + 2;
                    pend    = 1'b1;
                    pend_d  = e_dg;
                    cap_at  = mcyc + L;
                    resp_at = mcyc + L + 1;
                end
            end
        end
        chk("m_if_gnt",    64'(if_gnt),    64'(e_ig));
        chk("m_d_gnt",     64'(d_gnt),     64'(e_dg));
        chk("m_mem_en",    64'(mem_en),    64'(e_en));
        chk("m_mem_we",    64'(mem_we),    64'(e_we));
        chk("m_mem_addr",  64'(mem_addr),  64'(e_addr));
        chk("m_mem_wdata", 64'(mem_wdata), 64'(e_wd));
        chk("m_busy",      64'(busy),      64'(e_busy));
        chk("m_if_rvalid", 64'(if_rvalid), 64'(e_irv));
        chk("m_d_rvalid",  64'(d_rvalid),  64'(e_drv));
        chk("m_if_rdata",  64'(if_rdata),  64'(e_if_rdata));
        chk("m_d_rdata",   64'(d_rdata),   64'(e_d_rdata));
        mcyc++;
    end

    initial begin
        reset = 1; reset3 = 1;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0; reset3 = 0;
        smp();
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_rdata",  64'(if_rdata), 64'd0);

        // Single fetch, LAT=2
        step(); if_req = 1; if_addr = 16'h0010;
        smp();
        chk("t1_if_gnt",   64'(if_gnt),   64'd1);
        chk("t1_mem_en",   64'(mem_en),   64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h10);
        chk("t1_mem_we",   64'(mem_we),   64'd0);
        step(); if_req = 0;
        smp();  chk("t1_busy_t1", 64'(busy), 64'd1);
        step(); mem_rdata = 32'hDEADBEEF;
        smp();  chk("t1_rvalid_t2", 64'(if_rvalid), 64'd0);
        step(); mem_rdata = 32'h0;
        smp();
        chk("t1_rvalid_t3", 64'(if_rvalid), 64'd1);
        chk("t1_rdata_t3",  64'(if_rdata),  64'hDEADBEEF);
        chk("t1_busy_t3",   64'(busy),      64'd1);
        step();
        smp();
        chk("t1_busy_t4",    64'(busy),     64'd0);
        chk("t1_rdata_hold", 64'(if_rdata), 64'hDEADBEEF);

        // Both requests held after reset: fetch first, then alternate
        step(); reset = 1; reset3 = 1;
        step(); reset = 0; reset3 = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                if_req = 1; d_req = 1; d_we = 0; d_addr = 16'h0030; if_addr = 16'h0040;
            end
            if (k == 9) begin
                if_req = 0; d_req = 0;
            end
            mem_rdata = 32'hC000_0000 + 32'(k);
            smp();
            chk($sformatf("t2_if_gnt_k%0d", k), 64'(if_gnt), 64'(k == 0 || k == 8));
            chk($sformatf("t2_d_gnt_k%0d", k),  64'(d_gnt),  64'(k == 4));
            if (k == 7) begin
                chk("t2_d_rvalid", 64'(d_rvalid), 64'd1);
                chk("t2_d_rdata",  64'(d_rdata),  64'hC000_0006);
            end
            step();
        end

        // Write on tie (data's turn), pending fetch granted next cycle
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'h12345678;
        if_req = 1; if_addr = 16'h0100;
        smp();
        chk("t3_d_gnt",     64'(d_gnt),     64'd1);
        chk("t3_if_gnt",    64'(if_gnt),    64'd0);
        chk("t3_mem_we",    64'(mem_we),    64'd1);
        chk("t3_mem_addr",  64'(mem_addr),  64'h20);
        chk("t3_mem_wdata", 64'(mem_wdata), 64'h12345678);
        step(); d_req = 0; d_we = 0;
        smp();
        chk("t3_if_gnt_t1", 64'(if_gnt),   64'd1);
        chk("t3_addr_t1",   64'(mem_addr), 64'h100);
        chk("t3_no_drv",    64'(d_rvalid), 64'd0);

        // Data request arriving while the fetch read is outstanding
        step(); if_req = 0; d_req = 1; d_addr = 16'h0044;
        for (int k = 1; k <= 3; k++) begin
            smp();
            chk($sformatf("t4_d_gnt_wait%0d", k), 64'(d_gnt), 64'd0);
            if (k == 3) chk("t4_if_rvalid", 64'(if_rvalid), 64'd1);
            step();
        end
        smp();
        chk("t4_d_gnt",    64'(d_gnt),    64'd1);
        chk("t4_mem_addr", 64'(mem_addr), 64'h44);
        step(); d_req = 0;
        repeat (5) step();

        // LAT=3 instance: reset during RD_WAIT discards the read
        reset3 = 1;
        step(); reset3 = 0;
        if_req = 1; if_addr = 16'h0050;
        smp();
        chk("t5_if_gnt3", 64'(if_gnt3), 64'd1);
        chk("t5_mem_en3", 64'(mem_en3), 64'd1);
        step(); reset3 = 1;
        smp();
        chk("t5_rst_gnt3",   64'(if_gnt3),   64'd0);
        chk("t5_rst_busy3",  64'(busy3),     64'd0);
        chk("t5_rst_en3",    64'(mem_en3),   64'd0);
        chk("t5_rst_rdata3", 64'(if_rdata3), 64'd0);
        step(); reset3 = 0; if_req = 0;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk($sformatf("t5_no_rvalid_%0d", k), 64'(if_rvalid3), 64'd0);
            chk($sformatf("t5_idle_%0d", k),      64'(busy3),      64'd0);
            step();
        end
        if_req = 1; d_req = 1; d_we = 0;
        smp();
        chk("t5_tie_if_gnt3", 64'(if_gnt3), 64'd1);
        chk("t5_tie_d_gnt3",  64'(d_gnt3),  64'd0);
        step(); if_req = 0; d_req = 0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, memory address width.
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter LAT, default 2, memory read latency in cycles; legal range 1..7.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port if_req  input  1  instruction-fetch read request.
REQ-007 SHALL have port if_addr  input  AW  fetch address.
REQ-008 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port if_rvalid  output  1  fetch read data valid, one-cycle pulse.
REQ-010 SHALL have port if_rdata  output  DW  fetch read data.
REQ-011 SHALL have port d_req  input  1  data load/store request.
REQ-012 SHALL have port d_we  input  1  data request is a write (1) or read (0).
REQ-013 SHALL have port d_addr  input  AW  data address.
REQ-014 SHALL have port d_wdata  input  DW  store data.
REQ-015 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid  output  1  load data valid, one-cycle pulse.
REQ-017 SHALL have port d_rdata  output  DW  load data.
REQ-018 SHALL have port mem_en, mem_we  output  1 each  memory enable and write strobe.
REQ-019 SHALL have port mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW  single-port memory bus.
REQ-020 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, RD_WAIT, RESP; grants are issued only in IDLE.
REQ-022 SHALL, in IDLE with exactly one request high, grant that requester in the same cycle (combinational gnt).
REQ-023 SHALL, in IDLE with both requests high, grant the requester not granted most recently (round-robin); last_owner updates on every grant.
REQ-024 SHALL, in the grant cycle T, drive mem_en=1, mem_addr from the winner, and mem_we=d_we and mem_wdata=d_wdata for a data grant; mem_we=0 for fetch.
REQ-025 SHALL drive mem_en, mem_we, mem_addr, and mem_wdata to 0 in every cycle without a grant.
REQ-026 SHALL, on a write grant, remain in IDLE with no rvalid generated, allowing a new grant at T+1.
REQ-027 SHALL, on a read grant, enter RD_WAIT and load a 3-bit counter with LAT-1, decrementing each cycle.
REQ-028 SHALL, in RD_WAIT with counter 0 (cycle T+LAT), register mem_rdata into the granted port's rdata register and enter RESP.
REQ-029 SHALL, in RESP (cycle T+LAT+1), pulse the owner's rvalid for exactly one cycle, then return to IDLE; earliest next grant is T+LAT+2.
REQ-030 SHALL hold each rdata output stable until that port's next read response; the other port's rdata SHALL be unaffected.
REQ-031 SHALL, in RD_WAIT or RESP, ignore requests; gnt stays 0 and requesters hold req, addr, and wdata stable until gnt.
REQ-032 SHALL treat req still high in the cycle after its gnt as a new request.
REQ-033 SHALL, with LAT=1, enter RESP directly after the grant cycle's RD_WAIT, with mem_rdata sampled at T+1 and rvalid at T+2.

Reset
REQ-034 SHALL, on reset, force state IDLE, counter 0, last_owner=data (so fetch wins the first tie), and all outputs (gnt, rvalid, rdata, mem_*, busy) to 0.
REQ-035 SHALL, on reset asserted during RD_WAIT or RESP, discard the outstanding read with no rvalid pulse after reset release.

Verification
REQ-036 SHALL verify: LAT=2, if_req only, if_addr=0x0010, mem_rdata=0xDEADBEEF at T+2 -> if_gnt at T, mem_en=1 with mem_addr=0x0010 at T, if_rvalid=1 with if_rdata=0xDEADBEEF at T+3, busy high T+1..T+3.
REQ-037 SHALL verify: after reset, if_req and d_req both held -> if_gnt first, d_gnt next at T+LAT+2; with both held continuously, grants alternate.
REQ-038 SHALL verify: d_req with d_we=1, addr 0x0020, wdata 0x12345678 -> d_gnt, mem_en=1, mem_we=1, no d_rvalid; a pending if_req is granted at T+1.
REQ-039 SHALL verify: d_req arriving during RD_WAIT of a fetch -> d_gnt=0 until IDLE, with d_addr unchanged when finally driven on mem_addr.
REQ-040 SHALL verify: reset pulsed at T+1 of a LAT=3 read -> no if_rvalid afterwards, all outputs 0, and the next tie is granted to fetch.
